// File: rtl/ccff_loader_if.sv
// ccff_loader_if: host word handshake, chain serial pins and status of one ccff_loader
//   start/data_in/data_valid/data_ready : host side, bit 0 of data_in shifted first
//   ccff_head/ccff_tail/shift_en        : chain head, chain tail, chain shift request
//   busy/done/pass/crc_out              : sequence status and load CRC
interface ccff_loader_if #(
    parameter int WORD_W = 8
);
    logic              start;
    logic [WORD_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              shift_en;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       crc_out;
    modport slave (
        input  start, data_in, data_valid, ccff_tail,
        output data_ready, ccff_head, shift_en, busy, done, pass, crc_out
    );
    modport master (
        output start, data_in, data_valid, ccff_tail,
        input  data_ready, ccff_head, shift_en, busy, done, pass, crc_out
    );
endinterface

// File: rtl/ccff_loader.sv
// ccff_loader: serializes a host bitstream into a config flop chain, recirculates it once and compares CRC-16s
//   prog_clk : configuration clock
//   pReset   : synchronous active-high reset
//   bus      : slave view of ccff_loader_if (host handshake, chain pins, status)
module ccff_loader #(
    parameter int CHAIN_LEN = 18,
    parameter int WORD_W    = 8
) (
    input logic          prog_clk,
    input logic          pReset,
    ccff_loader_if.slave bus
);
    localparam int WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int WL_W  = $clog2(WORDS + 1);
    localparam int BT_W  = $clog2(CHAIN_LEN + 1);
    localparam int BL_W  = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [WL_W-1:0]   words_left_q, words_left_d;
    logic [BT_W-1:0]   bits_total_q, bits_total_d;
    logic [BL_W-1:0]   bits_left_q, bits_left_d;
    logic [15:0]       load_crc_q, load_crc_d;
    logic [15:0]       rb_crc_q, rb_crc_d;
    logic [15:0]       crc_out_q, crc_out_d;
    logic              pass_q, pass_d;
    logic              shift_en, data_ready, accept;
    logic [31:0]       rem;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    assign shift_en   = (state_q == LOAD && bits_left_q != '0) || state_q == VERIFY;
    assign data_ready = state_q == LOAD && words_left_q != '0 &&
                        (bits_left_q == '0 || (bits_left_q == BL_W'(1) && shift_en));
    assign accept     = data_ready && bus.data_valid;
    // bits still owed to the chain once this cycle's shift (if any) has happened
    assign rem        = 32'(bits_total_q) - 32'(shift_en);

    assign bus.shift_en   = shift_en;
    assign bus.data_ready = data_ready;
    assign bus.ccff_head  = state_q == VERIFY ? bus.ccff_tail : (state_q == LOAD && sr_q[0]);
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = state_q == DONE;
    assign bus.pass       = pass_q;
    assign bus.crc_out    = crc_out_q;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        words_left_d = words_left_q;
        bits_total_d = bits_total_q;
        bits_left_d  = bits_left_q;
        load_crc_d   = load_crc_q;
        rb_crc_d     = rb_crc_q;
        crc_out_d    = crc_out_q;
        pass_d       = pass_q;
        unique case (state_q)
            IDLE: if (bus.start) begin
                state_d      = LOAD;
                sr_d         = '0;
                words_left_d = WL_W'(WORDS);
                bits_total_d = BT_W'(CHAIN_LEN);
                bits_left_d  = '0;
                load_crc_d   = 16'hFFFF;
                rb_crc_d     = 16'hFFFF;
                pass_d       = 1'b0;
            end
            LOAD: begin
                if (shift_en) begin
                    load_crc_d   = crc_step(load_crc_q, sr_q[0]);
                    bits_total_d = bits_total_q - BT_W'(1);
                    bits_left_d  = bits_left_q - BL_W'(1);
                    // the last bit of a word stays at bit 0 so ccff_head holds through a stall
                    if (bits_left_q != BL_W'(1)) sr_d = sr_q >> 1;
                    if (bits_total_q == BT_W'(1)) begin
                        state_d      = VERIFY;
                        bits_total_d = BT_W'(CHAIN_LEN);
                    end
                end
                if (accept) begin
                    sr_d         = bus.data_in;
                    words_left_d = words_left_q - WL_W'(1);
                    bits_left_d  = BL_W'((rem < 32'(WORD_W)) ? rem : 32'(WORD_W));
                end
            end
            VERIFY: begin
                rb_crc_d     = crc_step(rb_crc_q, bus.ccff_tail);
                bits_total_d = bits_total_q - BT_W'(1);
                if (bits_total_q == BT_W'(1)) begin
                    state_d   = DONE;
                    pass_d    = load_crc_q == rb_crc_d;
                    crc_out_d = load_crc_q;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            words_left_q <= '0;
            bits_total_q <= '0;
            bits_left_q  <= '0;
            load_crc_q   <= '0;
            rb_crc_q     <= '0;
            crc_out_q    <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            words_left_q <= words_left_d;
            bits_total_q <= bits_total_d;
            bits_left_q  <= bits_left_d;
            load_crc_q   <= load_crc_d;
            rb_crc_q     <= rb_crc_d;
            crc_out_q    <= crc_out_d;
            pass_q       <= pass_d;
        end
    end
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: directed checks of ccff_loader against behavioural chain models
module tb_ccff_loader;
    logic clk = 1'b0;
    logic p_reset = 1'b1;
    always #5 clk = ~clk;

    ccff_loader_if #(.WORD_W(8)) b();
    ccff_loader_if #(.WORD_W(1)) b1();

    ccff_loader #(.CHAIN_LEN(18), .WORD_W(8)) u_dut (.prog_clk(clk), .pReset(p_reset), .bus(b));
    ccff_loader #(.CHAIN_LEN(1),  .WORD_W(1)) u_deg (.prog_clk(clk), .pReset(p_reset), .bus(b1));

    // chain[0] is the head-side flop, chain[17] drives ccff_tail
    logic [17:0] chain = '0;
    logic        c1 = 1'b0;
    logic        flip = 1'b0;
    assign b.ccff_tail  = chain[17];
    assign b1.ccff_tail = c1;
    always @(posedge clk) if (b.shift_en) chain <= {chain[16:0], b.ccff_head} ^ (flip ? 18'h00080 : 18'h00000);
    always @(posedge clk) if (b1.shift_en) c1 <= b1.ccff_head;

    int cnt = 0;
    int t0 = 0;
    logic rec = 1'b0;
    logic [63:0] se_tr, hd_tr, dn_tr, rd_tr;
    always @(posedge clk) cnt <= cnt + 1;
    always @(negedge clk) if (rec && cnt - t0 < 64) begin
        if (cnt == t0) begin
            se_tr <= '0;
            hd_tr <= '0;
            dn_tr <= '0;
            rd_tr <= '0;
        end
        se_tr[cnt - t0] <= b.shift_en;
        hd_tr[cnt - t0] <= b.ccff_head;
        dn_tr[cnt - t0] <= b.done;
        rd_tr[cnt - t0] <= b.data_ready;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] crc_model(input logic [17:0] h, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) c = (c << 1) ^ ((c[15] ^ h[k]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    function automatic logic [17:0] rev18(input logic [17:0] h);
        logic [17:0] r;
        for (int k = 0; k < 18; k++) r[17 - k] = h[k];
        return r;
    endfunction

    function automatic logic [63:0] ones(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic begin_seq();
        b.start = 1'b1;
        t0 = cnt;
        rec = 1'b1;
        tick();
        b.start = 1'b0;
    endtask

    // withholds data_valid for the first `hold` cycles in which data_ready is high
    task automatic send(input logic [7:0] w, input int hold);
        int t;
        b.data_in = w;
        b.data_valid = 1'b0;
        for (t = 0; t < 200; t++) begin
            if (b.data_ready && hold == 0) break;
            if (b.data_ready) hold--;
            tick();
        end
        if (t == 200) check("send_ready", 64'(b.data_ready), 64'd1);
        b.data_valid = 1'b1;
        tick();
        b.data_valid = 1'b0;
    endtask

    task automatic run_seq(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input int hold, input int flip_at, input int start_at, input int snap_at,
                           output int dcyc, output logic busy_after, output logic [17:0] snap);
        begin_seq();
        send(w0, 0);
        send(w1, hold);
        send(w2, hold);
        dcyc = -1;
        snap = '0;
        for (int t = 0; t < 100 && dcyc < 0; t++) begin
            if (cnt - t0 == snap_at) snap = chain;
            if (b.done) dcyc = cnt - t0;
            else begin
                flip = (cnt - t0 == flip_at);
                b.start = (cnt - t0 == start_at);
                tick();
            end
        end
        flip = 1'b0;
        b.start = 1'b0;
        if (dcyc < 0) check("done_seen", 64'(b.done), 64'd1);
        tick();
        busy_after = b.busy;
    endtask

    logic [17:0] h_nom = 18'h23CA5;
    logic [17:0] h_ff  = 18'h33CA5;
    logic [15:0] crc_nom;
    logic [17:0] snap;
    logic        ba;
    int          d;
    int          d1;
    int          t1;

    initial begin
        b.start = 1'b0; b.data_valid = 1'b0; b.data_in = '0;
        b1.start = 1'b0; b1.data_valid = 1'b0; b1.data_in = '0;
        repeat (3) tick();
        check("reset_outs", 64'({b.data_ready, b.shift_en, b.ccff_head, b.busy, b.done, b.pass, b.crc_out}), 64'd0);
        p_reset = 1'b0;
        tick();
        b.start = 1'b1; p_reset = 1'b1;
        tick();
        b.start = 1'b0; p_reset = 1'b0;
        check("start_vs_reset", 64'(b.busy), 64'd0);

        // nominal back-to-back load and verify
        crc_nom = crc_model(h_nom, 18);
        run_seq(8'hA5, 8'h3C, 8'h02, 0, -1, -1, 20, d, ba, snap);
        check("nom_done_cyc", 64'(d), 64'd38);
        check("nom_shift_en", se_tr, ones(2, 37));
        check("nom_head", 64'(hd_tr[19:2]), 64'(h_nom));
        check("nom_done_pulse", dn_tr, ones(38, 38));
        check("nom_ready", rd_tr, ones(1, 1) | ones(9, 9) | ones(17, 17));
        check("nom_pass", 64'(b.pass), 64'd1);
        check("nom_crc", 64'(b.crc_out), 64'(crc_nom));
        check("nom_chain_load", 64'(snap), 64'(rev18(h_nom)));
        check("nom_chain_end", 64'(chain), 64'(rev18(h_nom)));
        check("nom_idle_after", 64'(ba), 64'd0);

        // three-cycle stalls before words 2 and 3
        run_seq(8'hA5, 8'h3C, 8'h02, 3, -1, -1, 26, d, ba, snap);
        check("stall_done_cyc", 64'(d), 64'd44);
        check("stall_shift_en", se_tr, ones(2, 9) | ones(13, 20) | ones(24, 43));
        check("stall_head_gap1", 64'(hd_tr[12:9]), 64'hF);
        check("stall_head_gap2", 64'(hd_tr[23:20]), 64'h0);
        check("stall_chain", 64'(chain), 64'(rev18(h_nom)));
        check("stall_crc", 64'(b.crc_out), 64'(crc_nom));
        check("stall_pass", 64'(b.pass), 64'd1);

        // flop 7 corrupted at the end of LOAD
        run_seq(8'hA5, 8'h3C, 8'h02, 0, 19, -1, 20, d, ba, snap);
        check("corr_chain", 64'(snap), 64'(rev18(h_nom) ^ 18'h00080));
        check("corr_done_cyc", 64'(d), 64'd38);
        check("corr_pass", 64'(b.pass), 64'd0);
        check("corr_crc", 64'(b.crc_out), 64'(crc_nom));

        // reset in the middle of LOAD, then a clean sequence
        begin_seq();
        send(8'hA5, 0);
        repeat (8) tick();
        p_reset = 1'b1;
        tick();
        check("mid_reset_outs", 64'({b.data_ready, b.shift_en, b.ccff_head, b.busy, b.done, b.pass, b.crc_out}), 64'd0);
        p_reset = 1'b0;
        run_seq(8'hA5, 8'h3C, 8'h02, 0, -1, -1, 20, d, ba, snap);
        check("reload_done_cyc", 64'(d), 64'd38);
        check("reload_pass", 64'(b.pass), 64'd1);
        check("reload_chain", 64'(chain), 64'(rev18(h_nom)));

        // start during VERIFY, 0xFF as a partial final word
        run_seq(8'hA5, 8'h3C, 8'hFF, 0, -1, 25, 20, d, ba, snap);
        check("busy_done_cyc", 64'(d), 64'd38);
        check("busy_idle_after", 64'(ba), 64'd0);
        check("ff_head", 64'(hd_tr[19:2]), 64'(h_ff));
        check("ff_shift_en", se_tr, ones(2, 37));
        check("ff_ready", rd_tr, ones(1, 1) | ones(9, 9) | ones(17, 17));
        check("ff_chain", 64'(chain), 64'(rev18(h_ff)));
        check("ff_crc", 64'(b.crc_out), 64'(crc_model(h_ff, 18)));
        check("ff_pass", 64'(b.pass), 64'd1);

        // degenerate CHAIN_LEN=1, WORD_W=1
        b1.data_in = 1'b1;
        b1.data_valid = 1'b1;
        b1.start = 1'b1;
        t1 = cnt;
        tick();
        b1.start = 1'b0;
        d1 = -1;
        for (int t = 0; t < 20 && d1 < 0; t++) begin
            if (b1.done) d1 = cnt - t1;
            else tick();
        end
        b1.data_valid = 1'b0;
        check("deg_done_cyc", 64'(d1), 64'd4);
        check("deg_pass", 64'(b1.pass), 64'd1);
        check("deg_crc", 64'(b1.crc_out), 64'(crc_model(18'h00001, 1)));
        check("deg_chain", 64'(c1), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration-chain loader for the tile configuration flip-flop chain (ccff_head → … → ccff_tail) that programs routing-mux memories in connection and switch blocks. It accepts a bitstream from a host as words over a valid/ready handshake and serializes it LSB-first onto ccff_head. It then recirculates the chain once (ccff_tail → ccff_head) to read it back non-destructively, and compares a CRC-16 of the loaded bits against a CRC-16 of the read-back bits. It sits between the fabric configuration port and the head of one chain. It drives a shift-enable consumed by the chain's prog_clk gate.

## Interface
- CHAIN_LEN, 18, number of configuration flip-flops in the driven chain (≥1)
- WORD_W, 8, host word width (≥1)
- prog_clk  in  1  configuration clock; all state updates on rising edge
- pReset  in  1  synchronous, active-high reset
- start  in  1  begin a load/verify sequence; sampled only in IDLE
- data_in  in  WORD_W  bitstream word; bit 0 shifted first
- data_valid  in  1  data_in valid
- data_ready  out  1  block accepts data_in this cycle
- ccff_head  out  1  serial bit into chain head
- ccff_tail  in  1  serial bit from chain tail
- shift_en  out  1  chain must shift at end of this cycle
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at sequence end
- pass  out  1  CRCs matched; valid from done, held until next start
- crc_out  out  16  CRC of loaded bitstream, held until next start

## Operation
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE → LOAD on start. Clear the counters, set both CRCs to 0xFFFF, and clear pass.
- start is ignored outside IDLE.
- Counters:
  - words_left = ceil(CHAIN_LEN/WORD_W).
  - bits_total counts down from CHAIN_LEN.
  - bits_left counts the bits remaining in the shift register.
  - Counter widths are clog2(max+1).
- LOAD handshake:
  - data_ready = LOAD && words_left≠0 && (bits_left==0 || (bits_left==1 && shift_en)).
  - On accept, the shift register loads data_in.
  - bits_left loads min(WORD_W, bits_total remaining).
  - Upper bits of a final partial word are ignored.
- LOAD shifting:
  - shift_en = (LOAD && bits_left≠0) || VERIFY.
  - ccff_head = shift register bit 0 in LOAD.
  - Each LOAD shift advances the load CRC with ccff_head and decrements bits_total.
- LOAD stall: if no word is available when bits_left==0, shift_en=0 and ccff_head holds. The chain holds its contents.
- LOAD → VERIFY when the last bit shifts (bits_total reaches 0).
- VERIFY:
  - ccff_head = ccff_tail (combinational).
  - Runs for exactly CHAIN_LEN cycles.
  - Each cycle advances the readback CRC with ccff_tail.
  - The chain contents after VERIFY equal the contents after LOAD.
- VERIFY → DONE after CHAIN_LEN shifts.
- DONE (one cycle):
  - done=1.
  - pass = (load CRC == readback CRC).
  - crc_out = load CRC.
  - Then → IDLE.
- CRC: CRC-16-CCITT, polynomial 0x1021, serial MSB-feedback form. The feedback bit is crc[15]^bit.
- Outputs ccff_head, shift_en, data_ready and done are 0 in IDLE.

## Timing
- Reset (pReset=1 at an edge) takes effect at that edge:
  - State → IDLE.
  - data_ready=0, shift_en=0, ccff_head=0, busy=0, done=0.
  - pass=0, crc_out=0x0000, all counters 0.
- Reset mid-sequence aborts immediately; shift_en drops the next cycle. Chain contents are then undefined; the host must reload.
- start high at cycle 0 → LOAD and data_ready=1 at cycle 1.
- A word accepted at cycle n produces its first shift at cycle n+1.
- With data_valid held high there are no bubbles: the next word is accepted in the cycle its predecessor's last bit shifts.
- Minimum sequence: done at cycle 2 + 2·CHAIN_LEN after start (cycle 38 for CHAIN_LEN=18).
- The chain captures ccff_head at the rising edge ending each cycle in which shift_en=1.
- ccff_tail is the chain's last flop output and is sampled in the same cycle.
- Simultaneous start and pReset: reset wins.
- Simultaneous pReset and a valid handshake: the word is dropped.

## Test plan
- Nominal load and verify:
  - Stimulus: CHAIN_LEN=18, WORD_W=8, words 0xA5, 0x3C, 0x02 back-to-back, behavioural 18-flop chain model.
  - Head sequence: 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 0,1.
  - shift_en high cycles 2–19 and 20–37; done at 38; pass=1.
  - Chain contents unchanged after VERIFY.
- Stalls:
  - Stimulus: data_valid low for 3 cycles between each word.
  - shift_en=0 and ccff_head stable during the gaps.
  - Final chain and crc_out identical to the nominal scenario; done delayed by 6 cycles.
- Corruption detection: the chain model flips flop 7 after LOAD → pass=0 at done; crc_out unchanged.
- Reset mid-LOAD: pReset at cycle 10 → all outputs at reset values at cycle 11. A fresh start then completes with pass=1.
- Start while busy and partial word:
  - A start pulse during VERIFY is ignored.
  - 0xFF as the final word shifts only 2 ones.
  - data_ready is 0 after the 3rd word for the remainder of the sequence.
- Degenerate sizes: CHAIN_LEN=1, WORD_W=1, one word 0x1 → done at cycle 4, pass=1.
